fetch_aligner: RTL

FETCH_ALIGNER -- requirements
Module: fetch_aligner

---
 rtl/y86_pkg.sv | 20 ++
 rtl/instr_len.sv | 17 +
 rtl/fetch_aligner.sv | 120 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 icode, instruction-length and fetch-state definitions.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] LEN_1  = 4'd1;
    localparam logic [3:0] LEN_2  = 4'd2;
    localparam logic [3:0] LEN_9  = 4'd9;
    localparam logic [3:0] LEN_10 = 4'd10;
    typedef enum logic {S_RUN, S_HALTED} state_t;
endpackage

// File: rtl/instr_len.sv
// instr_len: decodes an icode into instruction length and field-presence flags.
module instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic [3:0] len_o,
    output logic       need_regids_o,
    output logic       need_valc_o,
    output logic       invalid_o
);
    assign invalid_o     = icode_i > I_POPQ;
    assign need_regids_o = icode_i inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
    assign need_valc_o   = icode_i inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    assign len_o = invalid_o ? LEN_1 :
                   need_valc_o ? (need_regids_o ? LEN_10 : LEN_9) :
                   need_regids_o ? LEN_2 : LEN_1;
endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: byte-stream to Y86 instruction aligner over a circular buffer; FETCH_ALIGNER_STATS_EN adds instr_count.
module fetch_aligner
    import y86_pkg::*;
#(
    parameter int          FETCH_BYTES = 4,
    parameter int          BUF_BYTES   = 16,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*FETCH_BYTES-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [63:0]              flush_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_icode,
    output logic [3:0]               out_ifun,
    output logic [3:0]               out_rA,
    output logic [3:0]               out_rB,
    output logic [63:0]              out_valC,
    output logic [63:0]              out_pc,
    output logic [63:0]              out_valP,
    output logic                     out_instr_err,
    output logic                     halted
`ifdef FETCH_ALIGNER_STATS_EN
    ,
    output logic [31:0]              instr_count
`endif
);
    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = $clog2(BUF_BYTES + 1);

    logic [7:0]    buf_q [BUF_BYTES];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   pc_q;
    state_t        state_q;
    logic [79:0]   win;
    logic [3:0]    len;
    logic          need_regids, need_valc, invalid, run, push, pop;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v >= BUF_BYTES ? v - BUF_BYTES : v);
    endfunction

    // Ten-byte window starting at the read pointer, unwrapped across the buffer end.
    always_comb begin
        win = '0;
        for (int k = 0; k < 10; k++) win[8*k +: 8] = buf_q[wrap(int'(rd_q) + k)];
    end

    instr_len u_len (
        .icode_i      (win[7:4]),
        .len_o        (len),
        .need_regids_o(need_regids),
        .need_valc_o  (need_valc),
        .invalid_o    (invalid)
    );

    assign run           = !rst && state_q == S_RUN;
    assign in_ready      = run && int'(count_q) <= BUF_BYTES - FETCH_BYTES;
    assign out_valid     = run && int'(count_q) >= int'(len);
    assign push          = in_valid && in_ready && !flush;
    assign pop           = out_valid && out_ready && !flush;
    assign count_d       = count_q + (push ? CW'(FETCH_BYTES) : '0) - (pop ? CW'(len) : '0);
    assign out_icode     = win[7:4];
    assign out_ifun      = win[3:0];
    assign out_rA        = need_regids ? win[15:12] : 4'hF;
    assign out_rB        = need_regids ? win[11:8] : 4'hF;
    assign out_valC      = !need_valc ? '0 : need_regids ? win[79:16] : win[71:8];
    assign out_pc        = pc_q;
    assign out_valP      = pc_q + 64'(len);
    assign out_instr_err = out_valid && invalid;
    assign halted        = !rst && state_q == S_HALTED;

    // Byte storage: an accepted beat lands at the write pointer, wrapping as needed.
    always_ff @(posedge clk) begin
        if (push)
            for (int i = 0; i < FETCH_BYTES; i++) buf_q[wrap(int'(wr_q) + i)] <= in_data[8*i +: 8];
    end

    // Pointers, occupancy, PC and run/halt state; rst beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC;
            state_q <= S_RUN;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            pc_q    <= flush_pc;
            state_q <= S_RUN;
        end else begin
            count_q <= count_d;
            if (push) wr_q <= wrap(int'(wr_q) + FETCH_BYTES);
            if (pop) begin
                rd_q <= wrap(int'(rd_q) + int'(len));
                pc_q <= out_valP;
                if (out_icode == I_HALT || invalid) state_q <= S_HALTED;
            end
        end
    end

`ifdef FETCH_ALIGNER_STATS_EN
    logic [31:0] instr_count_q;

    // Accepted-instruction counter; survives flush, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) instr_count_q <= '0;
        else if (pop) instr_count_q <= instr_count_q + 32'd1;
    end

    assign instr_count = instr_count_q;
`endif
endmodule
